// File: rtl/day01_pkg.sv
`timescale 1ns/1ps
// Shared types for the day01 frequency-repeat scanner: controller state
// encoding, default key width and the 32-bit signed ROM delta.
package day01_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int DELTA_W    = 32;

    typedef logic signed [DELTA_W-1:0] delta_t;

    typedef enum logic [2:0] {
        IDLE,
        QUERY,
        FETCH,
        ACCUM,
        DONE,
        FAIL
    } state_t;

endpackage

// File: rtl/day01_wrap_counter.sv
`timescale 1ns/1ps
// ROM address counter that wraps at N_ENTRIES-1, raising a wrap strobe and
// counting completed passes.
module day01_wrap_counter #(
    parameter int N_ENTRIES = 1024,
    parameter int ADDR_W    = 10,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              adv_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              wrap_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ENTRIES - 1);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    assign wrap_o  = adv_i && (addr_q == LAST_ADDR);
    assign addr_o  = addr_q;
    assign count_o = count_q;

    always_comb begin
        addr_d  = addr_q;
        count_d = count_q;
        if (clr_i) begin
            addr_d  = '0;
            count_d = '0;
        end else if (adv_i) begin
            if (wrap_o) begin
                addr_d  = '0;
                count_d = count_q + 1'b1;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/day01_scan_ctrl.sv
`timescale 1ns/1ps
// Scans a delta ROM accumulating a running sum and reports the first sum
// seen twice by an external seen-set. Define DAY01_PART1_EN for part1_sum.
module day01_scan_ctrl
    import day01_pkg::*;
#(
    parameter int N_ENTRIES  = 1024,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MAX_PASSES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic              set_req,
    output logic [DATA_W-1:0] set_key,
    input  logic              set_ack,
    input  logic              set_hit,
    output logic              done,
    output logic              timeout,
    output logic [DATA_W-1:0] result,
`ifdef DAY01_PART1_EN
    output logic [DATA_W-1:0] part1_sum,
`endif
    output logic [15:0]       passes,
    output state_t            dbg_state
);

    // Seen-set handshake: set_req stays high with set_key stable for the whole
    // QUERY state; the request completes on the first cycle set_ack is sampled
    // high, and set_ack outside QUERY is ignored.
    state_t            state_q, state_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              abort_q, abort_d;
    logic              cnt_clr, cnt_adv, cnt_wrap;
    logic [15:0]       pass_cnt;
    delta_t            delta;
    logic [DATA_W-1:0] delta_ext;
    logic              last_pass;
`ifdef DAY01_PART1_EN
    logic [DATA_W-1:0] part1_q, part1_d;
`endif

    assign delta     = rom_data;
    assign delta_ext = DATA_W'(delta);
    assign last_pass = (pass_cnt == 16'(MAX_PASSES - 1));

    day01_wrap_counter #(
        .N_ENTRIES (N_ENTRIES),
        .ADDR_W    (ADDR_W),
        .CNT_W     (16)
    ) u_wrap_counter (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (cnt_clr),
        .adv_i   (cnt_adv),
        .addr_o  (rom_addr),
        .wrap_o  (cnt_wrap),
        .count_o (pass_cnt)
    );

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        result_d = result_q;
        abort_d  = abort_q;
        cnt_clr  = 1'b0;
        cnt_adv  = 1'b0;
`ifdef DAY01_PART1_EN
        part1_d  = part1_q;
`endif
        case (state_q)
            IDLE: begin
                if (en) begin
                    cnt_clr = 1'b1;
                    sum_d   = '0;
                    abort_d = 1'b0;
                    state_d = QUERY;
`ifdef DAY01_PART1_EN
                    part1_d = '0;
`endif
                end
            end
            QUERY: begin
                // A dropped en must still let the outstanding request finish.
                if (!en) abort_d = 1'b1;
                if (set_ack) begin
                    if (abort_q || !en) begin
                        state_d = IDLE;
                    end else if (set_hit) begin
                        result_d = sum_q;
                        state_d  = DONE;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: state_d = en ? ACCUM : IDLE;
            ACCUM: begin
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    cnt_adv = 1'b1;
                    sum_d   = sum_q + delta_ext;
`ifdef DAY01_PART1_EN
                    if (cnt_wrap && (pass_cnt == 16'd0)) part1_d = sum_d;
`endif
                    if (cnt_wrap && last_pass) begin
                        result_d = sum_d;
                        state_d  = FAIL;
                    end else begin
                        state_d = QUERY;
                    end
                end
            end
            DONE, FAIL: if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sum_q    <= '0;
            result_q <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            abort_q  <= abort_d;
        end
    end

`ifdef DAY01_PART1_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) part1_q <= '0;
        else       part1_q <= part1_d;
    end
    assign part1_sum = part1_q;
`endif

    assign set_req   = (state_q == QUERY);
    assign set_key   = sum_q;
    assign done      = (state_q == DONE) || (state_q == FAIL);
    assign timeout   = (state_q == FAIL);
    assign result    = result_q;
    assign passes    = pass_cnt;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_day01_scan_ctrl.sv
`timescale 1ns/1ps
// Bench for day01_scan_ctrl: three instances (N=4, N=2 with MAX_PASSES=4,
// N=5) against a ROM model and a seen-set model with programmable ack delay.
module tb_day01_scan_ctrl;
  import day01_pkg::*;

  localparam int NI = 3;
  localparam int DW = 64;
  localparam int EW = 2 + 1 + 16 + DW;

  logic clk = 1'b0;
  logic reset;
  logic en [NI];
  logic [9:0] rom_addr [NI];
  logic [31:0] rom_data [NI];
  logic set_req [NI];
  logic set_ack [NI];
  logic set_hit [NI];
  logic done [NI];
  logic timeout [NI];
  logic [DW-1:0] set_key [NI];
  logic [DW-1:0] result [NI];
  logic [15:0] passes [NI];
  state_t dbg_state [NI];
`ifdef DAY01_PART1_EN
  logic [DW-1:0] part1_sum [NI];
`endif

  logic [31:0] rom_mem [NI][8];
  int dly_min [NI];
  int dly_max [NI];
  bit spur [NI];
  bit set_clr;
  logic [DW-1:0] seen_q[$];
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // ---------------- DUT instances ----------------
  for (genvar g = 0; g < NI; g++) begin : gen_dut
    localparam int N_E = (g == 0) ? 4 : (g == 1) ? 2 : 5;
    localparam int M_P = (g == 1) ? 4 : 1024;
    day01_scan_ctrl #(
      .N_ENTRIES(N_E), .ADDR_W(10), .DATA_W(DW), .MAX_PASSES(M_P)
    ) u_dut (
      .clk(clk), .reset(reset), .en(en[g]),
      .rom_addr(rom_addr[g]), .rom_data(rom_data[g]),
      .set_req(set_req[g]), .set_key(set_key[g]),
      .set_ack(set_ack[g]), .set_hit(set_hit[g]),
      .done(done[g]), .timeout(timeout[g]), .result(result[g]),
`ifdef DAY01_PART1_EN
      .part1_sum(part1_sum[g]),
`endif
      .passes(passes[g]), .dbg_state(dbg_state[g])
    );
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, $signed(act), act,
               $signed(req), req, $time);
    end
  endtask

  // ---------------- synchronous ROM model ----------------
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) rom_data[g] <= rom_mem[g][rom_addr[g][2:0]];
  end

  // ---------------- seen-set model ----------------
  initial begin : set_model
    int wait_c [NI];
    bit pend [NI];
    logic [DW-1:0] key0 [NI];
    bit found;
    for (int g = 0; g < NI; g++) begin
      set_ack[g] = 1'b0; set_hit[g] = 1'b0; pend[g] = 1'b0; wait_c[g] = 0; key0[g] = '0;
    end
    forever begin
      @(negedge clk);
      if (set_clr) seen_q.delete();
      for (int g = 0; g < NI; g++) begin
        set_ack[g] = 1'b0;
        set_hit[g] = 1'b0;
        if (set_req[g] && !reset) begin
          if (!pend[g]) begin
            pend[g] = 1'b1;
            wait_c[g] = $urandom_range(dly_max[g], dly_min[g]);
            key0[g] = set_key[g];
          end else begin
            check("key_stable", set_key[g], key0[g]);
          end
          if (wait_c[g] == 0) begin
            found = 1'b0;
            foreach (seen_q[i]) if (seen_q[i] == set_key[g]) found = 1'b1;
            if (!found) seen_q.push_back(set_key[g]);
            set_ack[g] = 1'b1;
            set_hit[g] = found;
            pend[g] = 1'b0;
          end else begin
            wait_c[g]--;
          end
        end else begin
          pend[g] = 1'b0;
          if (spur[g] && ($urandom_range(1, 0) == 1)) begin
            set_ack[g] = 1'b1;
            set_hit[g] = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [EW-1:0] e;
    bit prev [NI];
    for (int g = 0; g < NI; g++) prev[g] = 1'b0;
    forever begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        if (done[g] && !prev[g]) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 64'(g), 64'hFFFF);
          end else begin
            e = exp_q.pop_front();
            check("done_inst", 64'(g), 64'(e[EW-1 -: 2]));
            check("timeout", 64'(timeout[g]), 64'(e[EW-3]));
            check("passes", 64'(passes[g]), 64'(e[DW+15:DW]));
            check("result", result[g], e[DW-1:0]);
          end
        end
        prev[g] = done[g];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load(input int g, input int d[8], input int dmin, input int dmax, input bit sp);
    for (int i = 0; i < 8; i++) rom_mem[g][i] = d[i];
    dly_min[g] = dmin;
    dly_max[g] = dmax;
    spur[g] = sp;
  endtask

  task automatic clear_set();
    @(posedge clk); #1 set_clr = 1'b1;
    @(posedge clk); #1 set_clr = 1'b0;
  endtask

  task automatic run(input int g, input int d[8], input int dmin, input int dmax, input bit sp,
                     input bit exp_to, input int exp_p, input longint exp_r, input int exp_cyc);
    int cyc;
    load(g, d, dmin, dmax, sp);
    clear_set();
    exp_q.push_back({2'(g), exp_to, 16'(exp_p), 64'(exp_r)});
    en[g] = 1'b1;
    cyc = 0;
    while (!done[g] && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done[g]) begin
      check("done_wait", 64'(done[g]), 64'd1);
      void'(exp_q.pop_back());
    end else begin
      if (exp_cyc > 0) check("cycles_to_done", 64'(cyc), 64'(exp_cyc));
      repeat (3) @(posedge clk);
      #1;
      check("done_held", 64'(done[g]), 64'd1);
      check("result_held", result[g], 64'(exp_r));
    end
    en[g] = 1'b0;
    @(posedge clk); #1;
    check("done_clear", 64'(done[g]), 64'd0);
    check("timeout_clear", 64'(timeout[g]), 64'd0);
    check("state_idle", 64'(dbg_state[g]), 64'(IDLE));
  endtask

  task automatic wait_req(input int g);
    int cyc = 0;
    while (!set_req[g] && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("req_rise", 64'(set_req[g]), 64'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int cyc;
    reset = 1'b1;
    set_clr = 1'b0;
    for (int g = 0; g < NI; g++) begin
      en[g] = 1'b0; dly_min[g] = 0; dly_max[g] = 0; spur[g] = 1'b0;
      for (int i = 0; i < 8; i++) rom_mem[g][i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      check("rst_rom_addr", 64'(rom_addr[g]), 64'd0);
      check("rst_set_req", 64'(set_req[g]), 64'd0);
      check("rst_set_key", set_key[g], 64'd0);
      check("rst_done", 64'(done[g]), 64'd0);
      check("rst_timeout", 64'(timeout[g]), 64'd0);
      check("rst_result", result[g], 64'd0);
      check("rst_passes", 64'(passes[g]), 64'd0);
    end
    reset = 1'b0;

    // +1,-2,+3,+1 with zero-wait ack: 7 queries, hit on 2
    run(0, '{1, -2, 3, 1, 0, 0, 0, 0}, 0, 0, 1'b0, 1'b0, 1, 2, 20);
    // +1,-1: third query (key 0) hits
    run(1, '{1, -1, 0, 0, 0, 0, 0, 0}, 0, 0, 1'b0, 1'b0, 1, 0, 8);
    // +1,+1 never repeats: timeout after 4 passes with sum 8
    run(1, '{1, 1, 0, 0, 0, 0, 0, 0}, 0, 0, 1'b0, 1'b1, 4, 8, 25);
    // +3,+3,+4,-2,-4 with stray acks while idle of the handshake
    run(2, '{3, 3, 4, -2, -4, 0, 0, 0}, 0, 0, 1'b1, 1'b0, 1, 10, 23);
    // -6,+3,+8,+5,-6 with random 0..5 cycle ack delay
    run(2, '{-6, 3, 8, 5, -6, 0, 0, 0}, 0, 5, 1'b0, 1'b0, 2, 5, 0);

    // en dropped while the request is outstanding; seen-set still holds 0
    load(2, '{-6, 3, 8, 5, -6, 0, 0, 0}, 4, 4, 1'b0);
    en[2] = 1'b1;
    wait_req(2);
    en[2] = 1'b0;
    @(posedge clk); #1;
    check("req_held_after_en_drop", 64'(set_req[2]), 64'd1);
    cyc = 0;
    while (set_req[2] && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("req_drop_after_ack", 64'(set_req[2]), 64'd0);
    check("abort_state_idle", 64'(dbg_state[2]), 64'(IDLE));
    check("abort_no_done", 64'(done[2]), 64'd0);

    // reset asserted in the middle of a QUERY cycle
    en[2] = 1'b1;
    wait_req(2);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check("midq_rst_set_req", 64'(set_req[2]), 64'd0);
    check("midq_rst_rom_addr", 64'(rom_addr[2]), 64'd0);
    check("midq_rst_set_key", set_key[2], 64'd0);
    check("midq_rst_done", 64'(done[2]), 64'd0);
    check("midq_rst_timeout", 64'(timeout[2]), 64'd0);
    check("midq_rst_result", result[2], 64'd0);
    check("midq_rst_passes", 64'(passes[2]), 64'd0);
    check("midq_rst_state", 64'(dbg_state[2]), 64'(IDLE));
    en[2] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

`ifdef DAY01_PART1_EN
    run(2, '{7, 7, -2, -7, -4, 0, 0, 0}, 0, 0, 1'b0, 1'b0, 2, 14, 41);
    check("part1_sum", part1_sum[2], 64'd1);
`endif

    repeat (4) @(posedge clk);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
